// File: rtl/m_merge_pipe.sv
// Pipelined Batcher odd-even merger: two ascending lists of n keys -> one sorted list of 2n keys.
// One comparator layer per register stage, global stall on output backpressure, optional descending output.
module m_merge_pipe #(
  parameter int WIDTH = 3,
  parameter int n     = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_desc,
  input  logic [2*n*WIDTH-1:0]   inba,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*n*WIDTH-1:0]   c,
  output logic                   busy,
  output logic [CNT_W-1:0]       merge_cnt
);
  localparam int N      = 2*n;
  localparam int STAGES = $clog2(N);

  typedef logic [N-1:0][WIDTH-1:0] keys_t;

  keys_t             w_in  [STAGES];
  keys_t             w_cmp [STAGES];
  keys_t             w_last;
  keys_t             r_data [STAGES];
  logic [STAGES-1:0] r_vld;
  logic [STAGES-2:0] r_desc;
  logic              w_adv;
  logic              w_desc_last;

  assign w_adv       = ~r_vld[STAGES-1] | out_ready;
  assign in_ready    = w_adv;
  assign out_valid   = r_vld[STAGES-1];
  assign busy        = |r_vld;
  assign c           = r_data[STAGES-1];
  assign w_desc_last = r_desc[STAGES-2];

  // Layer s compares keys K = n>>s apart; the first layer pairs A[i] with B[i],
  // later layers pair the inner blocks of each 2K window.
  genvar s, x;
  generate
    for (s = 0; s < STAGES; s++) begin : g_stage
      localparam int K = n >> s;
      if (s == 0) begin : g_src0
        assign w_in[s] = inba;
      end else begin : g_srcn
        assign w_in[s] = r_data[s-1];
      end
      for (x = 0; x < N; x++) begin : g_lane
        localparam bit LO = (K == n) ? (x < n) :
                            ((x >= K) && (((x + K) % (2*K)) < K) && (x + K < N));
        localparam bit HI = (K == n) ? (x >= n) :
                            ((x >= 2*K) && ((x % (2*K)) < K));
        if (LO) begin : g_lo
          assign w_cmp[s][x] = (w_in[s][x] < w_in[s][x+K]) ? w_in[s][x] : w_in[s][x+K];
        end else if (HI) begin : g_hi
          assign w_cmp[s][x] = (w_in[s][x] < w_in[s][x-K]) ? w_in[s][x-K] : w_in[s][x];
        end else begin : g_pass
          assign w_cmp[s][x] = w_in[s][x];
        end
      end
    end
  endgenerate

  // Reversal sits in front of the output register so descending mode costs no latency.
  always_comb begin
    w_last = w_cmp[STAGES-1];
    if (w_desc_last) begin
      for (int i = 0; i < N; i++) w_last[i] = w_cmp[STAGES-1][N-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_desc    <= '0;
      merge_cnt <= '0;
      for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
    end else begin
      if (r_vld[STAGES-1] && out_ready) merge_cnt <= merge_cnt + CNT_W'(1);
      if (w_adv) begin
        r_vld     <= {r_vld[STAGES-2:0], in_valid};
        r_desc[0] <= in_desc;
        for (int i = 1; i < STAGES-1; i++) r_desc[i] <= r_desc[i-1];
        for (int i = 0; i < STAGES-1; i++) r_data[i] <= w_cmp[i];
        r_data[STAGES-1] <= w_last;
      end
    end
  end
endmodule

// File: tb/tb_m_merge_pipe.sv
// Bench for m_merge_pipe: n=8, n=2 (CNT_W=2) and n=16 instances against a queue-based
// transaction model that sorts each accepted input and tracks handshakes.
module tb_m_merge_pipe;
  localparam int KW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = '0, idesc = '0, ordy = '1;
  logic [47:0] inba8 = '0;
  logic [11:0] inba2 = '0;
  logic [95:0] inba16 = '0;
  wire  [2:0]  irdy, ovl, bsy;
  wire  [47:0] c8;
  wire  [11:0] c2;
  wire  [95:0] c16;
  wire  [15:0] cnt8;
  wire  [1:0]  cnt2;
  wire  [15:0] cnt16;

  int total = 0;
  int bad   = 0;

  // model: in-flight results per instance, oldest first, with edges advanced since accept
  logic [95:0] m_data [3][8];
  int          m_pos  [3][8];
  int          m_n    [3] = '{0, 0, 0};
  int          m_cnt  [3] = '{0, 0, 0};

  int          exp5 [5] = '{1, 2, 3, 0, 1};
  logic [95:0] items [8];
  bit   [7:0]  ds3;
  logic [95:0] got, v1, e1, held;
  int          idx3, cnt_before;

  m_merge_pipe #(.WIDTH(3), .n(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_desc(idesc[0]),
    .inba(inba8), .out_valid(ovl[0]), .out_ready(ordy[0]), .c(c8), .busy(bsy[0]),
    .merge_cnt(cnt8));
  m_merge_pipe #(.WIDTH(3), .n(2), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_desc(idesc[1]),
    .inba(inba2), .out_valid(ovl[1]), .out_ready(ordy[1]), .c(c2), .busy(bsy[1]),
    .merge_cnt(cnt2));
  m_merge_pipe #(.WIDTH(3), .n(16), .CNT_W(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_desc(idesc[2]),
    .inba(inba16), .out_valid(ovl[2]), .out_ready(ordy[2]), .c(c16), .busy(bsy[2]),
    .merge_cnt(cnt16));

  always #5 clk = ~clk;

  function automatic int nn_of(input int d);
    case (d) 0: return 8; 1: return 2; default: return 16; endcase
  endfunction
  function automatic int stg_of(input int d);
    case (d) 0: return 4; 1: return 2; default: return 5; endcase
  endfunction
  function automatic int cw_of(input int d);
    case (d) 1: return 2; default: return 16; endcase
  endfunction
  function automatic logic [95:0] in_of(input int d);
    case (d) 0: return {48'b0, inba8}; 1: return {84'b0, inba2}; default: return inba16; endcase
  endfunction
  function automatic logic [95:0] c_of(input int d);
    case (d) 0: return {48'b0, c8}; 1: return {84'b0, c2}; default: return c16; endcase
  endfunction
  function automatic int cnt_of(input int d);
    case (d) 0: return int'(cnt8); 1: return int'(cnt2); default: return int'(cnt16); endcase
  endfunction

  // Sort the low cnt keys of v; keys above cnt come back as zero.
  function automatic logic [95:0] sort_pack(input logic [95:0] v, input int cnt, input bit desc);
    int k[32];
    int t;
    logic [95:0] r;
    for (int i = 0; i < 32; i++) k[i] = (i < cnt) ? int'(v[i*KW +: KW]) : 0;
    for (int i = 0; i < cnt; i++)
      for (int j = 0; j < cnt-1-i; j++)
        if (k[j] > k[j+1]) begin t = k[j]; k[j] = k[j+1]; k[j+1] = t; end
    r = '0;
    for (int i = 0; i < cnt; i++) r[i*KW +: KW] = 3'(desc ? k[cnt-1-i] : k[i]);
    return r;
  endfunction

  function automatic logic [95:0] gen_item(input int nn);
    logic [95:0] a, b;
    a = sort_pack({$urandom, $urandom, $urandom}, nn, 1'b0);
    b = sort_pack({$urandom, $urandom, $urandom}, nn, 1'b0);
    return a | (b << (nn*KW));
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_one(input int d);
    bit eov;
    eov = (m_n[d] > 0) && (m_pos[d][0] == stg_of(d));
    chk($sformatf("d%0d out_valid", d), 96'(ovl[d]), 96'(eov));
    chk($sformatf("d%0d in_ready", d), 96'(irdy[d]), 96'(!eov || ordy[d]));
    chk($sformatf("d%0d busy", d), 96'(bsy[d]), 96'(m_n[d] > 0));
    chk($sformatf("d%0d merge_cnt", d), 96'(cnt_of(d)), 96'(m_cnt[d]));
    if (eov) chk($sformatf("d%0d c", d), c_of(d), m_data[d][0]);
  endtask

  // Apply what the coming rising edge will do, given the inputs now stable.
  task automatic step_one(input int d);
    bit eov, adv;
    eov = (m_n[d] > 0) && (m_pos[d][0] == stg_of(d));
    if (rst) begin m_n[d] = 0; m_cnt[d] = 0; return; end
    adv = !eov || ordy[d];
    if (!adv) return;
    if (eov) begin
      for (int i = 0; i < 7; i++) begin
        m_data[d][i] = m_data[d][i+1];
        m_pos[d][i]  = m_pos[d][i+1];
      end
      m_n[d]--;
      m_cnt[d] = (m_cnt[d] + 1) % (1 << cw_of(d));
    end
    for (int i = 0; i < m_n[d]; i++) m_pos[d][i]++;
    if (iv[d]) begin
      m_data[d][m_n[d]] = sort_pack(in_of(d), 2*nn_of(d), idesc[d]);
      m_pos[d][m_n[d]]  = 1;
      m_n[d]++;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) check_one(d);
    for (int d = 0; d < 3; d++) step_one(d);
  end

  task automatic set_in(input int d, input bit v, input bit ds, input logic [95:0] data);
    iv[d]    = v;
    idesc[d] = ds;
    case (d)
      0:       inba8  = data[47:0];
      1:       inba2  = data[11:0];
      default: inba16 = data;
    endcase
  endtask

  // One isolated merge; returns c in the first cycle out_valid is seen.
  task automatic lat_probe(input int d, input logic [95:0] data, input bit ds,
                           input int exp_lat, output logic [95:0] res);
    int cyc;
    cyc = 0;
    @(posedge clk); #2;
    set_in(d, 1'b1, ds, data);
    while (cyc < 20) begin
      @(posedge clk); #2;
      if (cyc == 0) set_in(d, 1'b0, 1'b0, '0);
      cyc++;
      #1;
      if (ovl[d]) break;
    end
    chk($sformatf("d%0d latency", d), 96'(cyc), 96'(exp_lat));
    res = c_of(d);
  endtask

  task automatic rand_run(input int d, input int num, input bit rnd_rdy);
    int idx, cyc;
    bit go, ds, done;
    logic [95:0] item;
    idx  = 0;
    done = 1'b0;
    item = gen_item(nn_of(d));
    ds   = 1'($urandom);
    for (cyc = 0; cyc < num*30 + 100 && !done; cyc++) begin
      @(posedge clk); #2;
      go = (idx < num) && ($urandom_range(0, 3) != 0);
      set_in(d, go, ds, item);
      ordy[d] = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk); #1;
      if (go && irdy[d]) begin
        idx++;
        item = gen_item(nn_of(d));
        ds   = 1'($urandom);
      end
      if (idx >= num && m_n[d] == 0) done = 1'b1;
    end
    @(posedge clk); #2;
    set_in(d, 1'b0, 1'b0, '0);
    ordy[d] = 1'b1;
    chk($sformatf("d%0d random run completed", d), 96'(done), 96'(1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("reset c8", {48'b0, c8}, '0);
    chk("reset c2", {84'b0, c2}, '0);
    chk("reset c16", c16, '0);
    chk("reset cnt8", 96'(cnt8), '0);
    chk("reset out_valid", 96'(ovl), '0);
    chk("reset busy", 96'(bsy), '0);
    chk("reset in_ready", 96'(irdy), 96'(3'b111));

    // A=0..7, B=0..7 ascending
    v1 = '0;
    e1 = '0;
    for (int k = 0; k < 8; k++) begin
      v1[k*KW +: KW]     = 3'(k);
      v1[(k+8)*KW +: KW] = 3'(k);
    end
    for (int i = 0; i < 16; i++) e1[i*KW +: KW] = 3'(i/2);
    lat_probe(0, v1, 1'b0, 4, got);
    chk("t1 c", got, e1);
    @(posedge clk); #3;
    chk("t1 merge_cnt", 96'(cnt8), 96'(1));

    // A all 7, B all 0, descending
    lat_probe(0, 96'h0000_0000_0000_00FF_FFFF, 1'b1, 4, got);
    chk("t2 c", got, 96'h0000_0000_0000_00FF_FFFF);
    @(posedge clk); #3;
    chk("t2 merge_cnt", 96'(cnt8), 96'(2));

    // eight back-to-back with out_ready low in cycles 6-8
    cnt_before = int'(cnt8);
    idx3 = 0;
    for (int i = 0; i < 8; i++) begin
      items[i] = gen_item(8);
      ds3[i]   = 1'($urandom);
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #2;
      set_in(0, idx3 < 8, ds3[idx3 % 8], items[idx3 % 8]);
      ordy[0] = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        chk($sformatf("t3 in_ready cycle %0d", cyc), 96'(irdy[0]), '0);
        if (cyc == 6) held = {48'b0, c8};
        else chk($sformatf("t3 c held cycle %0d", cyc), {48'b0, c8}, held);
      end
      @(negedge clk); #1;
      if (iv[0] && irdy[0]) idx3++;
    end
    @(posedge clk); #2;
    set_in(0, 1'b0, 1'b0, '0);
    ordy[0] = 1'b1;
    chk("t3 results delivered", 96'(int'(cnt8) - cnt_before), 96'(8));

    // reset while three merges are in flight
    @(posedge clk); #2;
    set_in(0, 1'b1, 1'b0, gen_item(8));
    @(posedge clk); #2;
    set_in(0, 1'b1, 1'b1, gen_item(8));
    @(posedge clk); #2;
    set_in(0, 1'b1, 1'b0, gen_item(8));
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    set_in(0, 1'b0, 1'b0, '0);
    #1;
    chk("t4 out_valid", 96'(ovl[0]), '0);
    chk("t4 busy", 96'(bsy), '0);
    chk("t4 merge_cnt", 96'(cnt8), '0);
    chk("t4 c", {48'b0, c8}, '0);
    lat_probe(0, gen_item(8), 1'b1, 4, got);
    @(posedge clk); #3;

    // 2-bit counter wraps
    for (int i = 0; i < 5; i++) begin
      lat_probe(1, gen_item(2), 1'($urandom), 2, got);
      @(posedge clk); #3;
      chk($sformatf("t5 cnt2 step %0d", i), 96'(cnt2), 96'(exp5[i]));
    end

    lat_probe(2, gen_item(16), 1'b0, 5, got);
    @(posedge clk); #3;

    rand_run(0, 60, 1'b1);
    rand_run(1, 100, 1'b0);
    rand_run(1, 100, 1'b1);
    rand_run(2, 100, 1'b0);
    rand_run(2, 100, 1'b1);

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
